// File: rtl/csd_pkg.sv
// -----------------------------------------------------------------------------
// csd_pkg
// Shared definitions for the canonical-signed-digit (CSD) datapath: word and
// memory geometry, the 8-bit digit codes stored in the digit memory, and the
// decoder state encoding.
// -----------------------------------------------------------------------------
package csd_pkg;

  localparam int N_DIGITS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int VAL_W    = N_DIGITS + 1;

  // One memory word per digit; any code not listed here is illegal.
  localparam logic [DATA_W-1:0] CSD_ZERO = 8'h00;
  localparam logic [DATA_W-1:0] CSD_POS  = 8'h01;
  localparam logic [DATA_W-1:0] CSD_NEG  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/csd_digit_map.sv
// -----------------------------------------------------------------------------
// csd_digit_map
// Combinational map from an 8-bit stored digit code to a 2-bit signed digit.
// Illegal codes map to digit 0 and raise the illegal flag, so a consumer can
// keep accumulating and simply report the error.
//
// Ports:
//   code    - 8-bit digit code read from the digit memory
//   digit   - signed digit in {-1, 0, +1}
//   illegal - code is none of CSD_ZERO / CSD_POS / CSD_NEG
// -----------------------------------------------------------------------------
module csd_digit_map
  import csd_pkg::*;
(
  input  logic [DATA_W-1:0] code,
  output logic signed [1:0] digit,
  output logic              illegal
);

  // Decode the stored code; defaults cover CSD_ZERO and illegal codes.
  always_comb begin
    digit   = 2'sb00;
    illegal = 1'b0;
    case (code)
      CSD_ZERO: digit = 2'sb00;
      CSD_POS:  digit = 2'sb01;
      CSD_NEG:  digit = 2'sb11;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csd_decoder.sv
// -----------------------------------------------------------------------------
// csd_decoder
// Reads a 16-digit CSD word from the shared digit memory, most significant
// digit first, and rebuilds its two's-complement value by Horner's rule
// (acc = 2*acc + d). Also reports illegal digit codes and non-canonical words
// (two adjacent nonzero digits).
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - begin one decode (only looked at while idle)
//   reCsd    - memory read enable
//   address  - memory read address, issued 15 down to 0
//   dataOut  - memory read data, valid the cycle after the address
//   value    - decoded signed result, held until the next decode completes
//   busy     - decode in progress
//   done     - one-cycle pulse when value and error flags are updated
//   err_code - an illegal digit code was seen in the last decode
//   err_adj  - adjacent nonzero digits were seen in the last decode
// -----------------------------------------------------------------------------
module csd_decoder
  import csd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              reCsd,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataOut,
  output logic [VAL_W-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic              err_code,
  output logic              err_adj
);

  state_t state;

  // sample_vld marks the cycles where dataOut holds a digit we asked for:
  // it is reCsd delayed by one cycle, matching the synchronous read.
  logic              sample_vld;
  logic [VAL_W-1:0]  acc;
  logic              errc;
  logic              erra;
  logic              prev_nz;

  logic signed [1:0] digit;
  logic              illegal;
  logic              cur_nz;
  logic [VAL_W-1:0]  acc_nxt;
  logic              errc_nxt;
  logic              erra_nxt;
  logic              prev_nz_nxt;

  csd_digit_map u_digit_map (
    .code    (dataOut),
    .digit   (digit),
    .illegal (illegal)
  );

  // Next accumulator and error state for the digit currently on dataOut.
  // Outside sampling cycles everything holds, so dataOut is ignored there.
  // Illegal codes already map to digit 0, so they never count as nonzero
  // for the adjacency check.
  always_comb begin
    acc_nxt     = acc;
    errc_nxt    = errc;
    erra_nxt    = erra;
    prev_nz_nxt = prev_nz;
    cur_nz      = 1'b0;
    if (sample_vld) begin
      cur_nz      = (digit != 2'sb00);
      acc_nxt     = (acc << 1) + {{(VAL_W-2){digit[1]}}, digit};
      errc_nxt    = errc | illegal;
      erra_nxt    = erra | (prev_nz & cur_nz);
      prev_nz_nxt = cur_nz;
    end
  end

  // Control FSM with registered outputs. Accumulation runs alongside FETCH
  // and DRAIN one cycle behind the address stream; the last digit arrives in
  // DRAIN, so results are published from acc_nxt on the DRAIN->DONE edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sample_vld <= 1'b0;
      acc        <= '0;
      errc       <= 1'b0;
      erra       <= 1'b0;
      prev_nz    <= 1'b0;
      reCsd      <= 1'b0;
      address    <= '0;
      value      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 1'b0;
      err_adj    <= 1'b0;
    end else begin
      sample_vld <= reCsd;
      acc        <= acc_nxt;
      errc       <= errc_nxt;
      erra       <= erra_nxt;
      prev_nz    <= prev_nz_nxt;

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            reCsd   <= 1'b1;
            address <= ADDR_W'(N_DIGITS - 1);
            acc     <= '0;
            errc    <= 1'b0;
            erra    <= 1'b0;
            prev_nz <= 1'b0;
          end
        end

        // The address register doubles as the down-counter.
        FETCH: begin
          if (address == '0) begin
            state <= DRAIN;
            reCsd <= 1'b0;
          end else begin
            address <= address - 1'b1;
          end
        end

        DRAIN: begin
          state    <= DONE;
          value    <= acc_nxt;
          err_code <= errc_nxt;
          err_adj  <= erra_nxt;
          done     <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csd_decoder.sv
// -----------------------------------------------------------------------------
// tb_csd_decoder
// Drives csd_decoder against a small synchronous digit memory and compares
// results with a reference that evaluates the CSD word as sum(d_k * 2^k).
// -----------------------------------------------------------------------------
module tb_csd_decoder;
  import csd_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              reCsd;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataOut;
  logic [VAL_W-1:0]  value;
  logic              busy;
  logic              done;
  logic              err_code;
  logic              err_adj;

  logic [7:0]  mem [N_DIGITS];
  int          total = 0;
  int          bad   = 0;
  logic [16:0] expVal;
  logic        expErrc;
  logic        expErra;
  logic [16:0] lastVal  = '0;
  logic        lastErrc = 1'b0;
  logic        lastErra = 1'b0;

  csd_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .reCsd    (reCsd),
    .address  (address),
    .dataOut  (dataOut),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .err_code (err_code),
    .err_adj  (err_adj)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory; when not read it returns junk so the decoder
  // has to ignore dataOut outside its sampling cycles.
  always @(posedge clk) begin
    if (reCsd) dataOut <= mem[address];
    else       dataOut <= 8'($urandom);
  end

  function automatic int digitOf(input logic [7:0] c);
    if (c == 8'h01) return 1;
    if (c == 8'hFF) return -1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic computeModel();
    int sum;
    int d;
    sum     = 0;
    expErrc = 1'b0;
    expErra = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      d = digitOf(mem[k]);
      sum += d * (1 << k);
      if (mem[k] != 8'h00 && mem[k] != 8'h01 && mem[k] != 8'hFF) expErrc = 1'b1;
      if (k > 0 && d != 0 && digitOf(mem[k-1]) != 0) expErra = 1'b1;
    end
    expVal = 17'(sum);
  endtask

  task automatic fillMem(input logic [7:0] base);
    for (int k = 0; k < N_DIGITS; k++) mem[k] = base;
  endtask

  task automatic fillOdd(input logic [7:0] code);
    for (int k = 0; k < N_DIGITS; k++) mem[k] = (k % 2 == 1) ? code : 8'h00;
  endtask

  task automatic fillRandom();
    int r;
    for (int k = 0; k < N_DIGITS; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      mem[k] = 8'h00;
      else if (r <= 7) mem[k] = 8'h01;
      else if (r == 8) mem[k] = 8'hFF;
      else             mem[k] = 8'($urandom_range(2, 254));
    end
  endtask

  // One decode from a start pulse: checks address stream, busy/done timing,
  // that results hold mid-run, and the final value and flags. againAt >= 0
  // raises start again during the run, which must be ignored.
  task automatic applyStimulus(input string tag, input int againAt);
    int reCnt, addrBad, doneAt, doneCnt, busyCnt;
    computeModel();
    reCnt = 0; addrBad = 0; doneAt = -1; doneCnt = 0; busyCnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start = (i == againAt);
      if (reCsd) begin
        reCnt++;
        if (address != 4'(15 - i)) addrBad++;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = i;
      end
      if (i == 5) begin
        checkOutput({tag, "_value_hold"}, 32'(value), 32'(lastVal));
        checkOutput({tag, "_flags_hold"}, {30'd0, err_code, err_adj}, {30'd0, lastErrc, lastErra});
      end
    end
    start = 1'b0;
    checkOutput({tag, "_recsd_cycles"}, 32'(reCnt), 32'd16);
    checkOutput({tag, "_addr_seq"}, 32'(addrBad), 32'd0);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'd18);
    checkOutput({tag, "_done_at"}, 32'(doneAt), 32'd17);
    checkOutput({tag, "_done_count"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, "_value"}, 32'(value), 32'(expVal));
    checkOutput({tag, "_err_code"}, 32'(err_code), 32'(expErrc));
    checkOutput({tag, "_err_adj"}, 32'(err_adj), 32'(expErra));
    lastVal  = expVal;
    lastErrc = expErrc;
    lastErra = expErra;
  endtask

  initial begin
    int doneCnt, firstDone, secondDone;
    reset = 1'b1;
    start = 1'b0;
    fillMem(8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state",
                32'({value, busy, done, err_code, err_adj, reCsd, address}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");

    fillMem(8'h00);
    applyStimulus("zeros", -1);

    fillMem(8'h00); mem[15] = 8'h01; mem[0] = 8'hFF;
    applyStimulus("msb_pos_lsb_neg", -1);
    checkOutput("msb_pos_lsb_neg_const", 32'(value), 32'd32767);

    fillOdd(8'h01);
    applyStimulus("odd_pos", -1);
    checkOutput("odd_pos_const", 32'(value), 32'd43690);

    fillOdd(8'hFF);
    applyStimulus("odd_neg", -1);
    checkOutput("odd_neg_const", 32'(value), 32'h15556);

    fillMem(8'h00); mem[4] = 8'h01; mem[3] = 8'hFF;
    applyStimulus("adjacent", -1);
    checkOutput("adjacent_const", {15'd0, value}, {15'd0, 17'd8});

    fillMem(8'h00);
    applyStimulus("clear_adj", -1);

    fillMem(8'h00); mem[7] = 8'h02;
    applyStimulus("illegal_restart", 5);

    // Start held high: second decode begins after a one-cycle idle gap.
    fillOdd(8'h01);
    computeModel();
    doneCnt = 0; firstDone = -1; secondDone = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 39; i++) begin
      @(posedge clk);
      #1;
      if (i == 30) start = 1'b0;
      if (done) begin
        doneCnt++;
        if (firstDone < 0) firstDone = i;
        else if (secondDone < 0) secondDone = i;
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", 32'(doneCnt), 32'd2);
    checkOutput("held_first_done", 32'(firstDone), 32'd17);
    checkOutput("held_second_done", 32'(secondDone), 32'd36);
    checkOutput("held_value", 32'(value), 32'(expVal));
    lastVal = expVal; lastErrc = expErrc; lastErra = expErra;

    // Reset in the middle of a decode.
    fillRandom();
    doneCnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_outputs",
                32'({value, busy, done, err_code, err_adj, reCsd, address}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done || reCsd) doneCnt++;
    end
    checkOutput("midrun_reset_quiet", 32'(doneCnt), 32'd0);
    lastVal = '0; lastErrc = 1'b0; lastErra = 1'b0;

    for (int n = 0; n < 8; n++) begin
      fillRandom();
      applyStimulus($sformatf("rand%0d", n), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csd_decoder.md
Name: csd_decoder

Overview:
- Reads a 16-digit canonical-signed-digit (CSD) word from the digit memory and reconstructs its signed binary value. This is the inverse of the CSD conversion datapath.
- Sits on the read side of the shared digit memory:
  - drives the memory's read enable and address;
  - consumes the memory's 8-bit read data;
  - reports the decoded value and validity flags to the controller.

Parameters:
- N_DIGITS, 16, number of CSD digits per word; digit at address k has weight 2^k.
- ADDR_W, 4, memory address width; N_DIGITS must equal 2^ADDR_W.
- DATA_W, 8, memory data width per digit.
- VAL_W, 17, width of the signed result (N_DIGITS+1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin one decode; sampled only in IDLE.
- reCsd  output  1  memory read enable.
- address  output  ADDR_W  memory read address.
- dataOut  input  DATA_W  memory read data; valid the cycle after reCsd/address are presented (synchronous read).
- value  output  VAL_W  signed decoded result; two's complement.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when value and flags are updated.
- err_code  output  1  an illegal digit code was read during the last decode.
- err_adj  output  1  two adjacent nonzero digits were read during the last decode (not canonical).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE;
  - value=0, busy=0, done=0, err_code=0, err_adj=0;
  - reCsd=0, address=0.
- Digit codes:
  - 8'h00 = 0;
  - 8'h01 = +1;
  - 8'hFF = -1;
  - any other code is illegal: it sets err_code and contributes 0.
- Evaluation order: MSB first. Addresses are issued 15, 14, ..., 0.
  - Accumulator update per digit: acc <= (acc <<< 1) + d, with d in {-1,0,+1} sign-extended to VAL_W.
  - No overflow is possible: |value| <= 2^16-1.
- States and transitions:
  - IDLE: start=1 -> FETCH; clear acc and the internal error flags; load the address counter with 15.
  - FETCH: reCsd=1, address=counter. The counter decrements every cycle. After address 0 is issued -> DRAIN.
  - ACCUMULATE: runs concurrently with FETCH and DRAIN, one cycle behind. The digit for address k is sampled on the edge after address k was presented.
  - DRAIN: one cycle. reCsd=0; the last digit (address 0) is accumulated -> DONE.
  - DONE: one cycle. value <= acc; err_code and err_adj are updated; done=1 -> IDLE.
- Timing:
  - Start sampled at edge E0.
  - reCsd is high for exactly 16 consecutive cycles, E0..E16.
  - done is high in the cycle after E17; start-to-done latency = 18 cycles.
  - busy is high during FETCH, DRAIN and DONE.
- Adjacency check: track the previous digit's nonzero status. If both the previous and the current digit are nonzero (±1), set internal err_adj. Illegal codes count as zero for this check.
- Outputs hold: value and the error flags keep their values until the next DONE. They are not cleared on start.
- Boundary conditions:
  - start while busy: ignored; no restart.
  - start held high: a new decode begins on the first IDLE cycle after DONE, i.e. back-to-back decodes with a one-cycle IDLE gap.
  - reset mid-operation: immediate return to IDLE. All outputs take their reset values; no done pulse.
  - dataOut is ignored outside the sampling cycles.

Decomposition:
- Shared package csd_pkg:
  - digit code constants CSD_ZERO=8'h00, CSD_POS=8'h01, CSD_NEG=8'hFF;
  - N_DIGITS, ADDR_W, DATA_W;
  - state enum {IDLE, FETCH, DRAIN, DONE}.
- One natural sub-module, csd_digit_map: combinational map of the 8-bit code to a 2-bit signed digit plus an illegal flag. It is shared with any future CSD consumer.
- The FSM, address down-counter, accumulator and adjacency check stay in csd_decoder.

Test Plan:
- All 16 addresses 8'h00, start -> value=0, err_code=0, err_adj=0; done exactly 18 cycles after start; reCsd high 16 cycles with addresses 15..0.
- addr15=01, addr0=FF, rest 00 -> value=32767, no errors.
- Odd addresses 01 (even 00) -> value=43690. Odd addresses FF -> value=-43690 (17'h15556). No errors in either case.
- addr4=01 and addr3=FF adjacent -> err_adj=1, value=8 (16-8); err_code=0. A following clean decode of all zeros clears err_adj.
- addr7=8'h02, rest 00 -> err_code=1, value=0. Plus start pulsed again at cycle 5 of the run -> ignored, exactly one done.
- Reset asserted at cycle 9 of a run -> outputs zero asynchronously, reCsd=0, no done; a subsequent start decodes correctly.
